// File: rtl/hiscore_bus_arbiter.sv
// Arbitrates the shared work RAM between the game CPU and the hiscore engine.
// Latency: the CPU path is combinational; an hs_read returns hs_rvalid RD_LAT cycles after issue.
// Backpressure: the engine waits on hs_grant; the CPU is halted through pause_req/cpu_paused.
// Optional HALT watchdog: define HS_ARB_WDOG_EN to enable it (default build: no watchdog).
module hiscore_bus_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk_49m,
  input  logic          reset,

  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          pause_req,
  input  logic          cpu_paused,

  input  logic          hs_access,
  input  logic          hs_read,
  input  logic          hs_write,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic          hs_grant,
  output logic          hs_rvalid,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_timeout,

  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  // One RAM request as seen at the mux output.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } ram_req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [RD_LAT-1:0] rd_pipe;
  logic              rd_issue;
  logic              pipe_empty;
  logic              release_done;
  logic              cpu_side;
  logic [DW-1:0]     rdata_q;
  logic              wdog_expire;
  ram_req_t          cpu_req;
  ram_req_t          hs_req;
  ram_req_t          ram_req;

  // The CPU always sees the raw RAM read data, whoever owns the bus.
  assign cpu_rdata = ram_rdata;

  // A read only counts when the engine owns the bus; a simultaneous write wins.
  assign rd_issue   = (state == GRANT) && hs_read && !hs_write;
  assign pipe_empty = ~|rd_pipe;

  // The bus may go back to the CPU once outstanding reads have drained and the CPU has resumed.
  assign release_done = (state == RELEASE) && pipe_empty && !cpu_paused;

  assign pause_req = (state == HALT) || (state == GRANT);
  assign hs_grant  = (state == GRANT);

`ifdef HS_ARB_WDOG_EN
  logic [15:0] wdog_cnt;

  // Abort the HALT wait if the CPU never acknowledges; a dropped hs_access takes precedence.
  assign wdog_expire = (state == HALT) && (wdog_cnt == 16'hFFFF) && !cpu_paused && hs_access;

  // Count consecutive HALT cycles; any exit from HALT clears the count.
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      wdog_cnt <= 16'd0;
    end else if ((state == HALT) && (state_nxt == HALT)) begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end else begin
      wdog_cnt <= 16'd0;
    end
  end

  logic timeout_q;

  // Single-cycle timeout pulse, aligned with the first RELEASE cycle after the abort.
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wdog_expire;
    end
  end

  assign hs_timeout = timeout_q;
`else
  // Without the watchdog HALT waits for the CPU indefinitely.
  assign wdog_expire = 1'b0;
  assign hs_timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hs_access) state_nxt = HALT;
      end
      HALT: begin
        if (!hs_access)      state_nxt = RELEASE;
        else if (cpu_paused) state_nxt = GRANT;
        else if (wdog_expire) state_nxt = RELEASE;
      end
      GRANT: begin
        if (!hs_access) state_nxt = RELEASE;
      end
      RELEASE: begin
        // Always passes through IDLE, so a re-asserted hs_access waits at least one IDLE cycle.
        if (release_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM mux: the engine drives the bus in GRANT and keeps the address until the release completes.
  always_comb begin
    cpu_req.addr  = cpu_addr;
    cpu_req.wdata = cpu_wdata;
    cpu_req.we    = cpu_cs & cpu_we;

    hs_req.addr   = hs_addr;
    hs_req.wdata  = hs_wdata;
    hs_req.we     = 1'b0;

    cpu_side = (state == IDLE) || (state == HALT) || release_done;

    if (state == GRANT) begin
      ram_req    = hs_req;
      ram_req.we = hs_write;
    end else if (cpu_side) begin
      ram_req = cpu_req;
    end else begin
      ram_req = hs_req;
    end
  end

  assign ram_addr  = ram_req.addr;
  assign ram_wdata = ram_req.wdata;
  // No RAM write may escape while reset is held.
  assign ram_we    = ram_req.we & reset;

  // Read tracking: one bit per issued read, shifting toward the data-return tap.
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // The last pipe stage marks the cycle the RAM presents this read's data.
  assign hs_rvalid = rd_pipe[RD_LAT-1] & reset;

  // Hold the most recently returned read data between valid pulses.
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (hs_rvalid) begin
      rdata_q <= ram_rdata;
    end
  end

  // Data is visible in the pulse cycle itself and held afterwards.
  assign hs_rdata = hs_rvalid ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_hiscore_bus_arbiter.sv
// Directed bench for hiscore_bus_arbiter (AW=16, DW=8, RD_LAT=2).
// Inputs change 1 ns after each rising edge; outputs are checked on the falling edge.
// The watchdog section adapts to whether HS_ARB_WDOG_EN is defined.
module tb_hiscore_bus_arbiter;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        pause_req, cpu_paused;
  logic        hs_access, hs_read, hs_write;
  logic [15:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic        hs_grant, hs_rvalid, hs_timeout;
  logic [7:0]  hs_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we;

  int n_assert = 0;
  int n_fail   = 0;

  hiscore_bus_arbiter #(.AW(16), .DW(8), .RD_LAT(2)) dut (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .pause_req (pause_req),
    .cpu_paused(cpu_paused),
    .hs_access (hs_access),
    .hs_read   (hs_read),
    .hs_write  (hs_write),
    .hs_addr   (hs_addr),
    .hs_wdata  (hs_wdata),
    .hs_grant  (hs_grant),
    .hs_rvalid (hs_rvalid),
    .hs_rdata  (hs_rdata),
    .hs_timeout(hs_timeout),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk_49m = ~clk_49m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_49m);
  endtask

  initial begin
    int t_first;
    int limit;

    reset = 1'b0; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
    cpu_paused = 1'b0; hs_access = 1'b0; hs_read = 1'b0; hs_write = 1'b0;
    hs_addr = 16'h0000; hs_wdata = 8'h00; ram_rdata = 8'h00;

    // Reset state, with a CPU write request held against reset.
    next_cycle(); mid();
    check("rst_ram_we",    ram_we,     0);
    check("rst_pause",     pause_req,  0);
    check("rst_grant",     hs_grant,   0);
    check("rst_rvalid",    hs_rvalid,  0);
    check("rst_rdata",     hs_rdata,   0);
    check("rst_timeout",   hs_timeout, 0);

    // IDLE: CPU write passes straight through.
    next_cycle(); reset = 1'b1; ram_rdata = 8'h77; mid();
    check("idle_we",    ram_we,    1);
    check("idle_addr",  ram_addr,  16'h1234);
    check("idle_wdata", ram_wdata, 8'h5A);
    check("cpu_rdata",  cpu_rdata, 8'h77);
    check("idle_pause", pause_req, 0);

    // IDLE with hs_access and an hs_write: write ignored, still IDLE this cycle.
    next_cycle(); hs_access = 1'b1; hs_write = 1'b1; cpu_we = 1'b0;
    hs_addr = 16'h0040; hs_wdata = 8'hA5; mid();
    check("a_pause",  pause_req, 0);
    check("a_we_ign", ram_we,    0);

    // H0: HALT, mux stays on CPU, hs_write still ignored.
    next_cycle(); mid();
    check("h0_pause", pause_req, 1);
    check("h0_grant", hs_grant,  0);
    check("h0_we",    ram_we,    0);
    check("h0_addr",  ram_addr,  16'h1234);

    // H1, H2: reads issued in HALT must not return data.
    next_cycle(); hs_write = 1'b0; hs_read = 1'b1; mid();
    check("h1_we", ram_we, 0);
    next_cycle(); mid();
    check("h2_rvalid", hs_rvalid, 0);

    // H3: CPU acknowledges three cycles after pause_req.
    next_cycle(); cpu_paused = 1'b1; hs_read = 1'b0; mid();
    check("h3_grant",  hs_grant,  0);
    check("h3_rvalid", hs_rvalid, 0);

    // H4: GRANT, engine write with a competing CPU write.
    next_cycle(); hs_write = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; mid();
    check("h4_grant",  hs_grant,  1);
    check("h4_pause",  pause_req, 1);
    check("h4_we",     ram_we,    1);
    check("h4_addr",   ram_addr,  16'h0040);
    check("h4_wdata",  ram_wdata, 8'hA5);
    check("h4_rvalid", hs_rvalid, 0);

    // H5: read and write together, write wins.
    next_cycle(); hs_read = 1'b1; hs_write = 1'b1; hs_addr = 16'h0041; mid();
    check("h5_we", ram_we, 1);

    // H6..H8: three back-to-back reads.
    next_cycle(); hs_write = 1'b0; hs_addr = 16'h0042; mid();
    check("h6_we",   ram_we,   0);
    check("h6_addr", ram_addr, 16'h0042);
    next_cycle(); hs_addr = 16'h0043; mid();
    check("h7_rvalid_drop", hs_rvalid, 0);
    next_cycle(); hs_addr = 16'h0044; ram_rdata = 8'h11; mid();
    check("h8_rvalid", hs_rvalid, 1);
    check("h8_rdata",  hs_rdata,  8'h11);
    next_cycle(); hs_read = 1'b0; ram_rdata = 8'h22; mid();
    check("h9_rvalid", hs_rvalid, 1);
    check("h9_rdata",  hs_rdata,  8'h22);
    next_cycle(); ram_rdata = 8'h33; mid();
    check("h10_rvalid", hs_rvalid, 1);
    check("h10_rdata",  hs_rdata,  8'h33);
    next_cycle(); ram_rdata = 8'h99; mid();
    check("h11_rvalid", hs_rvalid, 0);
    check("h11_hold",   hs_rdata,  8'h33);

    // H12: read, then hs_access drops while it is in flight.
    next_cycle(); hs_read = 1'b1; hs_addr = 16'h0050; mid();
    next_cycle(); hs_read = 1'b0; hs_access = 1'b0; mid();
    check("h13_grant", hs_grant, 1);
    next_cycle(); ram_rdata = 8'h44; mid();
    check("h14_pause",  pause_req, 0);
    check("h14_grant",  hs_grant,  0);
    check("h14_rvalid", hs_rvalid, 1);
    check("h14_rdata",  hs_rdata,  8'h44);

    // H15: RELEASE held by cpu_paused; hs_access re-asserted early.
    next_cycle(); hs_addr = 16'h0055; hs_access = 1'b1; mid();
    check("h15_addr",   ram_addr,  16'h0055);
    check("h15_we",     ram_we,    0);
    check("h15_rvalid", hs_rvalid, 0);
    check("h15_pause",  pause_req, 0);

    // H16: CPU resumes, bus returns to the CPU.
    next_cycle(); cpu_paused = 1'b0; mid();
    check("h16_addr", ram_addr, 16'h1234);
    check("h16_we",   ram_we,   1);

    // H17: one mandatory IDLE cycle, then HALT.
    next_cycle(); mid();
    check("h17_pause", pause_req, 0);
    check("h17_addr",  ram_addr,  16'h1234);
    next_cycle(); cpu_paused = 1'b1; mid();
    check("h18_pause", pause_req, 1);
    check("h18_grant", hs_grant,  0);

    // H19: GRANT with a read in flight, then reset.
    next_cycle(); hs_read = 1'b1; mid();
    check("h19_grant", hs_grant, 1);
    next_cycle(); reset = 1'b0; hs_read = 1'b0; hs_write = 1'b1; hs_access = 1'b0;
    cpu_paused = 1'b0; mid();
    check("h20_we_rst", ram_we, 0);
    next_cycle(); ram_rdata = 8'hEE; mid();
    check("h21_pause",   pause_req,  0);
    check("h21_grant",   hs_grant,   0);
    check("h21_rvalid",  hs_rvalid,  0);
    check("h21_rdata",   hs_rdata,   0);
    check("h21_timeout", hs_timeout, 0);
    check("h21_addr",    ram_addr,   16'h1234);
    next_cycle(); reset = 1'b1; hs_write = 1'b0; mid();
    check("h22_rvalid", hs_rvalid, 0);
    check("h22_pause",  pause_req, 0);

    // Watchdog: HALT with the CPU never acknowledging.
    next_cycle(); hs_access = 1'b1; mid();
    t_first = -1;
`ifdef HS_ARB_WDOG_EN
    limit = 65600;
`else
    limit = 3000;
`endif
    for (int i = 1; i <= limit; i++) begin
      next_cycle(); mid();
      if (hs_timeout) begin
        t_first = i;
        hs_access = 1'b0;
        break;
      end
    end
`ifdef HS_ARB_WDOG_EN
    // Entered HALT at step 1; expiry after 65535 counted cycles, pulse in the first RELEASE cycle.
    check("wdog_pulse_at", t_first, 65537);
    check("wdog_rel_pause", pause_req, 0);
    next_cycle(); mid();
    check("wdog_single", hs_timeout, 0);
    check("wdog_idle_pause", pause_req, 0);
    check("wdog_idle_addr", ram_addr, 16'h1234);
`else
    check("nowdog_pulse", t_first, -1);
    check("nowdog_halt", pause_req, 1);
    check("nowdog_grant", hs_grant, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
